inv_mix_column_seq: RTL and testbench
=====================================

Name: inv_mix_column_seq

Overview:
Iterative AES InvMixColumns engine for the decryption path. It is the inverse of the mixColumn stage.
- Accepts one 128-bit state over a valid/ready handshake.
- Transforms COLS_PER_CYCLE columns per clock.
- Holds the result until the consumer accepts it.
- Sits between the InvShiftRows/InvSubBytes/AddRoundKey stages of the decryption round pipeline.

Parameters:
COLS_PER_CYCLE, 1, columns processed per clock; legal values 1, 2, 4; calc latency = 4/COLS_PER_CYCLE cycles.

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  block is presented
in_ready  output  1  engine can accept a block
block  input  128  input state; byte 0 = block[127:120]; column c = block[127-32c -: 32]
out_valid  output  1  new_block holds a finished result
out_ready  input  1  consumer accepts the result
new_block  output  128  InvMixColumns(block), same byte ordering

Behaviour:
- Reset (async, rst_n=0): state=IDLE, col counter=0, work register=0, so new_block=0, in_ready=1, out_valid=0. Reset mid-CALC or mid-DONE aborts the block immediately; no result is emitted.
- FSM states: IDLE, CALC, DONE.
- IDLE:
  - in_ready=1, out_valid=0.
  - On an edge with in_valid=1, load block into the work register, col=0, go to CALC.
  - in_valid with in_ready=0 is ignored; the block is not captured.
- CALC:
  - in_ready=0, out_valid=0.
  - Each edge replaces columns col..col+COLS_PER_CYCLE-1 in place with the matrix product [0e 0b 0d 09; 09 0e 0b 0d; 0d 09 0e 0b; 0b 0d 09 0e] over GF(2^8), polynomial x^8+x^4+x^3+x+1 (0x11b).
  - Then col += COLS_PER_CYCLE.
  - After the edge processing the last column (col wraps to 0), go to DONE.
- DONE:
  - in_ready=0, out_valid=1, new_block stable.
  - On an edge with out_ready=1, go to IDLE.
  - out_ready held high before DONE has no effect.
- Latency (default COLS_PER_CYCLE=1):
  - Accept edge E0. out_valid goes high after edge E4 and stays high until the edge where out_ready=1.
  - Minimum period between accepts is 6 cycles.
  - There is no same-cycle drain and accept.
- new_block is always the work register. During CALC it is partially updated and is valid only when out_valid=1.
- Arithmetic is pure combinational GF multiply via xtime chains: 09=x8^x1, 0b=x8^x2^x1, 0d=x8^x4^x1, 0e=x8^x4^x2. There are no lookup tables.
- Control signals are stateful only; the datapath has no enable other than CALC.

Optional Feature:
Macro MIXCOL_FWD_EN.
- Defined:
  - Adds input port mode (1 bit), sampled and stored on the accept edge.
  - mode=0 gives InvMixColumns as above.
  - mode=1 gives forward MixColumns with matrix [02 03 01 01; 01 02 03 01; 01 01 02 03; 03 01 01 02].
  - The same FSM, timing and handshake apply; the stored mode is cleared to 0 on reset.
- Undefined: no mode port; the block is inverse-only.

Test Plan:
1. Reset then single block: block=8e4da1bc_9fdc589d_01010101_d5d5d7d6, in_valid one cycle.
   - out_valid rises exactly 4 cycles after the accept edge.
   - new_block=db135345_f20a225c_01010101_d4d4d4d5.
2. Backpressure: hold out_ready=0 for 10 cycles in DONE.
   - out_valid stays 1, new_block unchanged, in_ready stays 0.
   - A new in_valid is not captured.
   - Raise out_ready: IDLE next cycle and in_ready=1.
3. Fixed points: block=c6c6c6c6_01010101_00000000_ffffffff -> new_block identical to the input.
4. Async reset mid-CALC: drop rst_n 2 cycles after accept.
   - Outputs immediately become new_block=0, out_valid=0, in_ready=1.
   - No result is produced after reset release.
5. Round trip: 88 random blocks through the forward mixColumn reference model, then this block with out_ready=1.
   - Each output equals the original block.
   - Error count is 0.
6. MIXCOL_FWD_EN, mode=1: block=db135345_f20a225c_01010101_d4d4d4d5 -> new_block=8e4da1bc_9fdc589d_01010101_d5d5d7d6.

Source files
------------

// File: rtl/inv_mix_column_seq.sv
// Iterative AES InvMixColumns engine, COLS_PER_CYCLE columns per clock.
// Optional MIXCOL_FWD_EN adds a mode port selecting forward MixColumns.
module inv_mix_column_seq #(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] block,
`ifdef MIXCOL_FWD_EN
  input  logic         mode,
`endif
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] new_block
);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  localparam logic [1:0] STEP = 2'(COLS_PER_CYCLE);
  localparam logic [1:0] LAST = 2'(4 - COLS_PER_CYCLE);

  state_t       state_q;
  state_t       state_d;
  logic [1:0]   col_q;
  logic [127:0] work_q;
  logic [127:0] work_d;
  logic         fwd;

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] mix(
    input logic [31:0] c,
    input logic        f
  );
    logic [7:0] a [4];
    logic [7:0] x2 [4];
    logic [7:0] x4 [4];
    logic [7:0] x8 [4];
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    logic [7:0] m3 [4];
    logic [31:0] r;
    for (int i = 0; i < 4; i++) begin
      a[i]  = c[31-8*i -: 8];
      x2[i] = xt(a[i]);
      x4[i] = xt(x2[i]);
      x8[i] = xt(x4[i]);
      m9[i] = x8[i] ^ a[i];
      mb[i] = x8[i] ^ x2[i] ^ a[i];
      md[i] = x8[i] ^ x4[i] ^ a[i];
      me[i] = x8[i] ^ x4[i] ^ x2[i];
      m3[i] = x2[i] ^ a[i];
    end
    if (f) begin
      r = {x2[0] ^ m3[1] ^ a[2] ^ a[3],
           a[0] ^ x2[1] ^ m3[2] ^ a[3],
           a[0] ^ a[1] ^ x2[2] ^ m3[3],
           m3[0] ^ a[1] ^ a[2] ^ x2[3]};
    end else begin
      r = {me[0] ^ mb[1] ^ md[2] ^ m9[3],
           m9[0] ^ me[1] ^ mb[2] ^ md[3],
           md[0] ^ m9[1] ^ me[2] ^ mb[3],
           mb[0] ^ md[1] ^ m9[2] ^ me[3]};
    end
    return r;
  endfunction

`ifdef MIXCOL_FWD_EN
  logic mode_q;
  assign fwd = mode_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q <= 1'b0;
    end else if (state_q == IDLE && in_valid) begin
      mode_q <= mode;
    end
  end
`else
  assign fwd = 1'b0;
`endif

  // Only the columns selected by col_q are rewritten this cycle.
  always_comb begin
    logic [1:0] idx;
    idx    = '0;
    work_d = work_q;
    for (int k = 0; k < COLS_PER_CYCLE; k++) begin
      idx = col_q + 2'(k);
      work_d[127-32*int'(idx) -: 32] =
        mix(work_q[127-32*int'(idx) -: 32], fwd);
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (in_valid) state_d = CALC;
      CALC: if (col_q == LAST) state_d = DONE;
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      col_q   <= '0;
      work_q  <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && in_valid) begin
        work_q <= block;
        col_q  <= '0;
      end else if (state_q == CALC) begin
        work_q <= work_d;
        col_q  <= col_q + STEP;
      end
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign new_block = work_q;

endmodule

// File: tb/tb_inv_mix_column_seq.sv
// Scoreboard bench for inv_mix_column_seq against a GF(2^8)
// matrix reference model; random round trips through forward MixColumns.
module tb_inv_mix_column_seq;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] block = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [127:0] new_block;
`ifdef MIXCOL_FWD_EN
  logic         mode = 1'b0;
`endif

  int checks = 0;
  int errors = 0;
  logic [127:0] exp_q[$];

  localparam logic [127:0] T1_IN  = 128'h8e4da1bc_9fdc589d_01010101_d5d5d7d6;
  localparam logic [127:0] T1_OUT = 128'hdb135345_f20a225c_01010101_d4d4d4d5;
  localparam logic [127:0] FIXED  = 128'hc6c6c6c6_01010101_00000000_ffffffff;

  inv_mix_column_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .block     (block),
`ifdef MIXCOL_FWD_EN
    .mode      (mode),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .new_block (new_block)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    logic [7:0] y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
      y = y >> 1;
    end
    return p;
  endfunction

  // Circulant matrix: row r, column k uses base[(k - r) mod 4].
  function automatic logic [127:0] ref_mix(input logic [127:0] blk, input bit inv);
    logic [7:0] base[4];
    logic [7:0] s[16];
    logic [7:0] acc;
    logic [127:0] o = '0;
    if (inv) begin
      base[0] = 8'h0e; base[1] = 8'h0b; base[2] = 8'h0d; base[3] = 8'h09;
    end else begin
      base[0] = 8'h02; base[1] = 8'h03; base[2] = 8'h01; base[3] = 8'h01;
    end
    for (int i = 0; i < 16; i++) s[i] = blk[127-8*i -: 8];
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        acc = 8'h00;
        for (int k = 0; k < 4; k++)
          acc = acc ^ gmul(base[(k - r + 4) % 4], s[4*c+k]);
        o[127-8*(4*c+r) -: 8] = acc;
      end
    end
    return o;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    chk("ready_timeout", 128'(in_ready), 128'd1);
  endtask

  task automatic accept(input logic [127:0] b);
    wait_ready();
    in_valid = 1'b1;
    block    = b;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      tick();
      n++;
    end
    chk("drain", 128'(exp_q.size()), 128'd0);
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got %h expected none", new_block);
      end else begin
        chk("result", new_block, exp_q.pop_front());
      end
    end
  end

  initial begin
    logic [127:0] r;
    repeat (2) tick();
    chk("rst_new_block", new_block, '0);
    chk("rst_out_valid", 128'(out_valid), 128'd0);
    chk("rst_in_ready", 128'(in_ready), 128'd1);
    rst_n = 1'b1;
    tick();

    // Latency and known vector
    exp_q.push_back(ref_mix(T1_IN, 1'b1));
    accept(T1_IN);
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk($sformatf("lat_valid_%0d", i), 128'(out_valid), 128'(i == 4));
      chk($sformatf("lat_ready_%0d", i), 128'(in_ready), 128'd0);
    end
    chk("t1_vector", new_block, T1_OUT);

    // Backpressure, intruding in_valid ignored
    in_valid = 1'b1;
    block    = FIXED;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("bp_valid", 128'(out_valid), 128'd1);
      chk("bp_hold", new_block, T1_OUT);
      chk("bp_ready", 128'(in_ready), 128'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("drain_in_ready", 128'(in_ready), 128'd1);
    chk("drain_out_valid", 128'(out_valid), 128'd0);
    chk("drain_q", 128'(exp_q.size()), 128'd0);

    // Fixed points
    exp_q.push_back(FIXED);
    accept(FIXED);
    drain();
    chk("fixed_model", ref_mix(FIXED, 1'b1), FIXED);

    // Async reset mid-calc
    accept({$urandom, $urandom, $urandom, $urandom});
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    chk("arst_new_block", new_block, '0);
    chk("arst_out_valid", 128'(out_valid), 128'd0);
    chk("arst_in_ready", 128'(in_ready), 128'd1);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("arst_no_result", 128'(out_valid), 128'd0);
    end

    // Random round trips
    for (int n = 0; n < 88; n++) begin
      r = {$urandom, $urandom, $urandom, $urandom};
      exp_q.push_back(r);
      accept(ref_mix(r, 1'b0));
    end
    exp_q.push_back(T1_OUT);
    accept(T1_IN);
    drain();

`ifdef MIXCOL_FWD_EN
    mode = 1'b1;
    exp_q.push_back(T1_IN);
    accept(T1_OUT);
    mode = 1'b0;
    drain();
    chk("fwd_model", ref_mix(T1_OUT, 1'b0), T1_IN);
    exp_q.push_back(T1_OUT);
    accept(T1_IN);
    drain();
`endif

    repeat (3) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
